cylon_monitor: RTL and testbench
================================

# cylon_monitor

Receive-side checker for the one-eye cylon LED sweep. Samples an 8-bit display vector driven by the cylon generator, or looped back from the LED pins, and hunts for a known sweep position. It then tracks the 14-phase sweep (up 0→7, down 6→1), declares lock after a run of correct steps, and counts sequence errors and stalls. It sits beside the front-panel LED logic as a self-test and status source for VME readback.

## Interface
- MXERR, 8, width of the saturating error counter
- MXTMO, 23, width of the stall timeout counter; stall when no change for 2^MXTMO-1 clocks
- LOCK_CNT, 14, consecutive correct steps needed to move from TRACK to LOCKED (1..255)
- clock  in  1  system clock, 40 MHz; the only clock
- reset  in  1  asynchronous, active-high reset
- din  in  8  display vector under test, synchronous to clock
- err_clr  in  1  synchronous clear of err_cnt
- pointer  out  4  tracked sweep phase, 0..13
- dir  out  1  0 = sweeping up (phase 0..6), 1 = sweeping down (phase 7..13)
- valid  out  1  state is TRACK or LOCKED
- locked  out  1  state is LOCKED
- err_pulse  out  1  one-clock pulse per detected error
- err_cnt  out  MXERR  saturating count of errors
- stall  out  1  timeout seen; held until next din change

## Operation
- Input stage: din_ff <= din; prev_ff <= din_ff. A change is din_ff != prev_ff. All decisions are made only on change cycles.
- Phase-to-bit map: phase p in 0..7 lights bit p. Phase p in 8..13 lights bit 14-p. Next phase is p+1, with 13 wrapping to 0. Expected vector is the one-hot of next phase.
- Onehot is true when exactly one bit of din_ff is set. 0x00, 0xFF and any multi-bit value are invalid.
- HUNT: on change to 0x01, set phase 0. On change to 0x80, set phase 7. Either transition goes to TRACK with good_cnt = 0. Other values, including invalid ones, are ignored with no error.
- TRACK: on change, din_ff == expected gives phase++ and good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED. Any other value gives an error and a return to HUNT.
- LOCKED: on change, a match gives phase++. A mismatch or invalid value gives an error and a return to HUNT.
- Timeout: tmo_cnt clears on every change and increments otherwise. It saturates at 2^MXTMO-1.
  - Reaching saturation in TRACK or LOCKED sets stall, produces an error, and returns to HUNT.
  - In HUNT, saturation sets stall only, with no error.
- Error: err_pulse = 1 for one clock. err_cnt increments and saturates at all-ones.
- err_clr has priority over a same-cycle increment, so err_cnt = 0. err_pulse still fires.
- dir = (phase >= 7). pointer = phase; it is frozen at its last value while in HUNT.

## Timing
- Reset values: pointer 0, dir 0, valid 0, locked 0, err_pulse 0, err_cnt 0, stall 0, state HUNT, din_ff/prev_ff 0x00, tmo_cnt 0, good_cnt 0.
- Reset is asynchronous. Outputs go to reset values without a clock edge. Reset mid-TRACK or mid-LOCKED discards all history.
- Latency:
  - din new value at edge k lands in din_ff at edge k.
  - The change is evaluated and state/outputs update at edge k+1.
  - Total latency is 2 clocks from din to outputs.
- The first din value after reset is compared against prev_ff = 0x00. A constant 0x01 from reset therefore counts as one change.
- Lock time: LOCK_CNT correct changes after the hunt anchor. locked rises on the edge that evaluates the LOCK_CNT-th match.
- Stall: stall rises on the clock where tmo_cnt reaches 2^MXTMO-1. It clears on the edge that evaluates the next change.
- Simultaneous change and timeout cannot occur, because a change clears tmo_cnt first.
- All outputs are registered. There are no combinational paths from din.

## Test plan
- Reset, then drive a legal sweep stepping every 4 clocks from 0x01 (LOCK_CNT=14, MXTMO=6): TRACK after 0x01, locked=1 at the 14th match, pointer steps 0..13,0, and dir toggles at phases 7 and 0.
- Start the sweep at 0x08 rising: valid stays 0 through 0x08..0x40, and TRACK is entered at 0x80 with pointer 7 and dir 1.
- While locked at phase 3, drive 0x20 instead of 0x10: err_pulse is one clock, err_cnt=1, locked=0, and valid=0 two clocks after din.
- While locked, hold din constant for 63 clocks (MXTMO=6): stall=1, err_cnt+1, state HUNT. The next din change to 0x01 clears stall and re-enters TRACK.
- With MXERR=2, inject 5 errors: err_cnt holds at 3. Then assert err_clr on the same cycle as a 6th error: err_cnt=0 and err_pulse=1.
- While locked, assert reset asynchronously between edges: all outputs are 0 immediately. After release the block hunts again from 0x00 history.

Source files
------------

// File: rtl/cylon_monitor.sv
// Receive-side checker for the one-eye cylon sweep: hunts for an anchor position,
// tracks the 14-phase sweep, declares lock, and counts sequence errors and stalls.
module cylon_monitor #(
   parameter int MXERR    = 8,
   parameter int MXTMO    = 23,
   parameter int LOCK_CNT = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       din,
   input  logic             err_clr,
   output logic [3:0]       pointer,
   output logic             dir,
   output logic             valid,
   output logic             locked,
   output logic             err_pulse,
   output logic [MXERR-1:0] err_cnt,
   output logic             stall
);

   typedef enum logic [1:0] {HUNT = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [MXTMO-1:0] TMO_MAX   = '1;
   localparam logic [MXTMO-1:0] TMO_LAST  = TMO_MAX - 1'b1;
   localparam logic [7:0]       LOCK_GOAL = 8'(LOCK_CNT);

   function automatic logic [3:0] next_phase(input logic [3:0] p);
      return (p == 4'd13) ? 4'd0 : p + 4'd1;
   endfunction

   // Phases 8..13 retrace bits 6..1 on the way back down.
   function automatic logic [7:0] phase_vec(input logic [3:0] p);
      if (p <= 4'd7) return 8'd1 << p;
      else           return 8'd1 << (4'd14 - p);
   endfunction

   state_t           state, state_n;
   logic [7:0]       din_ff, prev_ff;
   logic [MXTMO-1:0] tmo_cnt;
   logic [7:0]       good_cnt, good_n;
   logic [3:0]       phase_n;
   logic             change, onehot, match, tmo_hit, err_evt;

   assign change  = (din_ff != prev_ff);
   assign onehot  = (din_ff != 8'd0) && ((din_ff & (din_ff - 8'd1)) == 8'd0);
   assign match   = onehot && (din_ff == phase_vec(next_phase(pointer)));
   // A change clears the timer, so a timeout can only land on a quiet cycle.
   assign tmo_hit = !change && (tmo_cnt == TMO_LAST);

   always_comb begin
      state_n = state;
      phase_n = pointer;
      good_n  = good_cnt;
      err_evt = 1'b0;
      if (change) begin
         case (state)
            HUNT: begin
               if (din_ff == 8'h01) begin
                  phase_n = 4'd0;
                  good_n  = 8'd0;
                  state_n = TRACK;
               end else if (din_ff == 8'h80) begin
                  phase_n = 4'd7;
                  good_n  = 8'd0;
                  state_n = TRACK;
               end
            end
            TRACK: begin
               if (match) begin
                  phase_n = next_phase(pointer);
                  good_n  = good_cnt + 8'd1;
                  if (good_cnt + 8'd1 == LOCK_GOAL) state_n = LOCKED;
               end else begin
                  err_evt = 1'b1;
                  state_n = HUNT;
               end
            end
            LOCKED: begin
               if (match) begin
                  phase_n = next_phase(pointer);
               end else begin
                  err_evt = 1'b1;
                  state_n = HUNT;
               end
            end
            default: state_n = HUNT;
         endcase
      end else if (tmo_hit && state != HUNT) begin
         err_evt = 1'b1;
         state_n = HUNT;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         din_ff    <= 8'd0;
         prev_ff   <= 8'd0;
         tmo_cnt   <= '0;
         good_cnt  <= 8'd0;
         pointer   <= 4'd0;
         dir       <= 1'b0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         stall     <= 1'b0;
      end else begin
         din_ff    <= din;
         prev_ff   <= din_ff;
         state     <= state_n;
         good_cnt  <= good_n;
         pointer   <= phase_n;
         dir       <= (phase_n >= 4'd7);
         valid     <= (state_n != HUNT);
         locked    <= (state_n == LOCKED);
         err_pulse <= err_evt;
         if (err_clr)
            err_cnt <= '0;
         else if (err_evt && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
         if (change)
            tmo_cnt <= '0;
         else if (tmo_cnt != TMO_MAX)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (change)
            stall <= 1'b0;
         else if (tmo_hit)
            stall <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cylon_monitor.sv
// Bench for cylon_monitor: randomized sweeps checked every clock against a
// sequence-level model of the hunt/track/lock behaviour.
module tb_cylon_monitor;

   localparam int MXERR    = 2;
   localparam int MXTMO    = 6;
   localparam int LOCK_CNT = 14;
   localparam int TMO_MAX  = (1 << MXTMO) - 1;
   localparam int CNT_MAX  = (1 << MXERR) - 1;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       din = 8'h00;
   logic             err_clr = 1'b0;
   logic [3:0]       pointer;
   logic             dir, valid, locked, err_pulse, stall;
   logic [MXERR-1:0] err_cnt;
   logic [10:0]      obs;

   cylon_monitor #(.MXERR(MXERR), .MXTMO(MXTMO), .LOCK_CNT(LOCK_CNT)) dut (
      .clock(clock), .reset(reset), .din(din), .err_clr(err_clr),
      .pointer(pointer), .dir(dir), .valid(valid), .locked(locked),
      .err_pulse(err_pulse), .err_cnt(err_cnt), .stall(stall)
   );

   always #5 clock = ~clock;

   assign obs = {pointer, dir, valid, locked, err_pulse, err_cnt, stall};

   int checks = 0;
   int errors = 0;

   // The sweep as seen on the LEDs, indexed by phase.
   logic [7:0] sweep [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

   // Model state: mode 0 = hunting, 1 = tracking, 2 = locked.
   int         m_mode, m_ptr, m_good, m_idle, m_cnt;
   bit         m_stall, m_pulse;
   logic [7:0] m_last, m_prev;

   task automatic model_reset();
      m_mode = 0; m_ptr = 0; m_good = 0; m_idle = 0; m_cnt = 0;
      m_stall = 0; m_pulse = 0; m_last = 8'h00; m_prev = 8'h00;
   endtask

   // One clock edge: the value seen two edges back is now judged against the one before it.
   task automatic model_edge(input logic [7:0] d, input logic clr);
      bit err;
      int nxt;
      err = 0;
      if (m_last != m_prev) begin
         m_idle  = 0;
         m_stall = 0;
         if (m_mode == 0) begin
            if (m_last == 8'h01)      begin m_ptr = 0; m_good = 0; m_mode = 1; end
            else if (m_last == 8'h80) begin m_ptr = 7; m_good = 0; m_mode = 1; end
         end else begin
            nxt = (m_ptr + 1) % 14;
            if (m_last == sweep[nxt]) begin
               m_ptr = nxt;
               if (m_mode == 1) begin
                  m_good++;
                  if (m_good == LOCK_CNT) m_mode = 2;
               end
            end else begin
               err = 1; m_mode = 0;
            end
         end
      end else if (m_idle < TMO_MAX) begin
         m_idle++;
         if (m_idle == TMO_MAX) begin
            m_stall = 1;
            if (m_mode != 0) begin err = 1; m_mode = 0; end
         end
      end
      m_pulse = err;
      if (clr) m_cnt = 0;
      else if (err && m_cnt < CNT_MAX) m_cnt++;
      m_prev = m_last;
      m_last = d;
   endtask

   function automatic logic [10:0] expv();
      return {4'(m_ptr), m_ptr >= 7, m_mode != 0, m_mode == 2, m_pulse, 2'(m_cnt), m_stall};
   endfunction

   task automatic tick();
      @(posedge clock);
      model_edge(din, err_clr);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b1; din = 8'h00; err_clr = 1'b0;
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (obs !== 11'd0) begin errors++; $display("FAIL reset_state: got %h expected 000", obs); end
      repeat (3) begin
         tick(); checks++;
         if (obs !== expv()) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, expv()); end
      end
   endtask

   task automatic test_sweep_lock();
      apply_reset();
      for (int i = 0; i < 21; i++) begin
         din = sweep[i % 14];
         repeat (4) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL sweep_lock step %0d: got %h expected %h", i, obs, expv()); end
         end
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL sweep_locked: got %b expected 1", locked); end
   endtask

   task automatic test_mid_start();
      apply_reset();
      for (int i = 3; i < 10; i++) begin
         din = sweep[i];
         repeat ($urandom_range(2, 5)) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL mid_start step %0d: got %h expected %h", i, obs, expv()); end
         end
         if (i == 7) begin
            checks++;
            if ({pointer, dir, valid} !== {4'd7, 1'b1, 1'b1}) begin
               errors++; $display("FAIL mid_anchor: got ptr=%0d dir=%b valid=%b expected ptr=7 dir=1 valid=1", pointer, dir, valid);
            end
         end
      end
   endtask

   task automatic test_seq_error();
      apply_reset();
      for (int i = 0; i < 18; i++) begin
         din = sweep[i % 14];
         repeat ($urandom_range(1, 4)) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL seq_error lead %0d: got %h expected %h", i, obs, expv()); end
         end
      end
      din = 8'h20;
      tick(); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL seq_error land: got %h expected %h", obs, expv()); end
      tick(); checks++;
      if ({err_pulse, err_cnt, locked, valid} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL seq_error hit: got pulse=%b cnt=%0d locked=%b valid=%b expected 1 1 0 0", err_pulse, err_cnt, locked, valid);
      end
      tick(); checks++;
      if (obs !== expv()) begin errors++; $display("FAIL seq_error after: got %h expected %h", obs, expv()); end
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         din = sweep[i % 14];
         repeat (2) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL stall lead %0d: got %h expected %h", i, obs, expv()); end
         end
      end
      repeat (70) begin
         tick(); checks++;
         if (obs !== expv()) begin errors++; $display("FAIL stall hold: got %h expected %h", obs, expv()); end
      end
      checks++;
      if ({stall, valid, err_cnt} !== {1'b1, 1'b0, 2'd1}) begin
         errors++; $display("FAIL stall_hit: got stall=%b valid=%b cnt=%0d expected 1 0 1", stall, valid, err_cnt);
      end
      din = 8'h01;
      repeat (2) tick();
      checks++;
      if ({stall, valid, pointer} !== {1'b0, 1'b1, 4'd0}) begin
         errors++; $display("FAIL stall_recover: got stall=%b valid=%b ptr=%0d expected 0 1 0", stall, valid, pointer);
      end
   endtask

   task automatic test_err_sat();
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         din = 8'h01;
         repeat (2) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL err_sat anchor %0d: got %h expected %h", k, obs, expv()); end
         end
         din = 8'h04;
         tick();
         if (k == 5) err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         checks++;
         if (obs !== expv()) begin errors++; $display("FAIL err_sat hit %0d: got %h expected %h", k, obs, expv()); end
         if (k == 4) begin
            checks++;
            if (err_cnt !== 2'd3) begin errors++; $display("FAIL err_saturate: got %0d expected 3", err_cnt); end
         end
         if (k == 5) begin
            checks++;
            if ({err_cnt, err_pulse} !== {2'd0, 1'b1}) begin
               errors++; $display("FAIL err_clr_priority: got cnt=%0d pulse=%b expected 0 1", err_cnt, err_pulse);
            end
         end
      end
   endtask

   task automatic test_random();
      int g, r, h;
      g = 0;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 80)      begin g = (g + 1) % 14; din = sweep[g]; end
         else if (r < 90) din = 8'($urandom);
         else             begin g = 0; din = 8'h01; end
         h = (n % 100 == 50) ? 66 : $urandom_range(1, 4);
         repeat (h) begin
            err_clr = ($urandom_range(0, 15) == 0);
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL random step %0d: got %h expected %h", n, obs, expv()); end
         end
      end
      err_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         din = sweep[i % 14];
         repeat (2) begin
            tick(); checks++;
            if (obs !== expv()) begin errors++; $display("FAIL async lead %0d: got %h expected %h", i, obs, expv()); end
         end
      end
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL async_prelock: got %b expected 1", locked); end
      #3 reset = 1'b1;
      #1 checks++;
      if (obs !== 11'd0) begin errors++; $display("FAIL async_reset: got %h expected 000", obs); end
      #2 reset = 1'b0;
      model_reset();
      repeat (3) begin
         tick(); checks++;
         if (obs !== expv()) begin errors++; $display("FAIL async_after: got %h expected %h", obs, expv()); end
      end
      din = 8'h01;
      repeat (3) begin
         tick(); checks++;
         if (obs !== expv()) begin errors++; $display("FAIL async_rehunt: got %h expected %h", obs, expv()); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sweep_lock();
      test_mid_start();
      test_seq_error();
      test_stall();
      test_err_sat();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
